// File: rtl/counter_ctrl.sv
// Sequencing controller for the outCounter datapath: programmable start/limit/step
// count runs driven by START/PAUSE/ABORT commands over a valid/ready handshake.
module counter_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic             cfg_wrap,
    output logic [WIDTH-1:0] outCounter,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]       OP_START = 2'b01;
    localparam logic [1:0]       OP_PAUSE = 2'b10;
    localparam logic [1:0]       OP_ABORT = 2'b11;
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   count_r, count_s;
    logic [WIDTH-1:0]   start_r, start_s;
    logic [WIDTH-1:0]   limit_r, limit_s;
    logic [WIDTH-1:0]   step_r, step_s;
    logic               wrap_cfg_r, wrap_cfg_s;
    logic               wrap_s;
    logic               load_s;
    logic               cmd_acc_s;
    logic [WIDTH:0]     sum_s;
    logic               busy_r, done_r, wrap_r, cmd_ready_r;

    // One extra bit keeps the limit compare correct when count+step exceeds 2^WIDTH-1.
    assign sum_s     = {1'b0, count_r} + {1'b0, step_r};
    assign cmd_acc_s = cmd_valid && cmd_ready_r;

    // Next-state, next-count and config-latch decode.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        start_s    = start_r;
        limit_s    = limit_r;
        step_s     = step_r;
        wrap_cfg_s = wrap_cfg_r;
        wrap_s     = 1'b0;
        load_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_acc_s && (cmd_op == OP_START)) begin
                    load_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cmd_acc_s && (cmd_op == OP_START)) begin
                    load_s = 1'b1;
                end else if (cmd_acc_s && (cmd_op == OP_PAUSE)) begin
                    state_s = ST_PAUSE;
                end else if (cmd_acc_s && (cmd_op == OP_ABORT)) begin
                    state_s = ST_IDLE;
                end else if (sum_s >= {1'b0, limit_r}) begin
                    if (wrap_cfg_r) begin
                        count_s = start_r;
                        wrap_s  = 1'b1;
                    end else begin
                        count_s = limit_r;
                        state_s = ST_DONE;
                    end
                end else begin
                    count_s = sum_s[WIDTH-1:0];
                end
            end
            ST_PAUSE: begin
                if (cmd_acc_s && (cmd_op == OP_START)) begin
                    state_s = ST_RUN;
                end else if (cmd_acc_s && (cmd_op == OP_ABORT)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // A fresh START reloads everything; a zero step would stall, so it becomes 1.
        if (load_s) begin
            count_s    = cfg_start;
            start_s    = cfg_start;
            limit_s    = cfg_limit;
            step_s     = (cfg_step == ZERO_VAL) ? ONE_VAL : cfg_step;
            wrap_cfg_s = cfg_wrap;
            state_s    = (cfg_start >= cfg_limit) ? ST_DONE : ST_RUN;
        end else begin
            wrap_cfg_s = wrap_cfg_s;
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            count_r     <= ZERO_VAL;
            start_r     <= ZERO_VAL;
            limit_r     <= ZERO_VAL;
            step_r      <= ONE_VAL;
            wrap_cfg_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            wrap_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            start_r     <= start_s;
            limit_r     <= limit_s;
            step_r      <= step_s;
            wrap_cfg_r  <= wrap_cfg_s;
            busy_r      <= (state_s == ST_RUN) || (state_s == ST_PAUSE);
            done_r      <= (state_s == ST_DONE);
            wrap_r      <= wrap_s;
            cmd_ready_r <= (state_s != ST_DONE);
        end
    end

    assign outCounter = count_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign wrap       = wrap_r;
    assign cmd_ready  = cmd_ready_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed test-plan runs plus random commands, all
// compared every cycle against an integer-arithmetic reference model.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cfg_start = 8'd0;
    logic [7:0] cfg_limit = 8'd0;
    logic [7:0] cfg_step = 8'd0;
    logic       cfg_wrap = 1'b0;
    logic [7:0] outCounter;
    logic       busy, done, wrap;

    int passed = 0;
    int total  = 0;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_mode = M_IDLE, m_cnt = 0, m_st = 0, m_lim = 0, m_step = 1;
    bit m_wc = 1'b0, m_wrap = 1'b0;

    counter_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cfg_start(cfg_start), .cfg_limit(cfg_limit),
        .cfg_step(cfg_step), .cfg_wrap(cfg_wrap), .outCounter(outCounter),
        .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: drive inputs at negedge, advance the model, sample #1 after posedge.
    task automatic cyc(input string tag, input bit r, input bit v, input bit [1:0] op,
                       input int s, input int l, input int st, input bit w);
        bit acc;
        @(negedge clk);
        rst = r; cmd_valid = v; cmd_op = op;
        cfg_start = 8'(s); cfg_limit = 8'(l); cfg_step = 8'(st); cfg_wrap = w;
        acc = v && (m_mode != M_DONE);
        m_wrap = 1'b0;
        if (r) begin
            m_mode = M_IDLE; m_cnt = 0; m_st = 0; m_lim = 0; m_step = 1; m_wc = 1'b0;
        end else if ((m_mode == M_IDLE || m_mode == M_RUN) && acc && op == 2'd1) begin
            m_cnt = s; m_st = s; m_lim = l; m_step = (st == 0) ? 1 : st; m_wc = w;
            m_mode = (s >= l) ? M_DONE : M_RUN;
        end else if (m_mode == M_RUN) begin
            if (acc && op == 2'd2) m_mode = M_PAUSE;
            else if (acc && op == 2'd3) m_mode = M_IDLE;
            else if (m_cnt + m_step >= m_lim) begin
                if (m_wc) begin m_cnt = m_st; m_wrap = 1'b1; end
                else begin m_cnt = m_lim; m_mode = M_DONE; end
            end else m_cnt = m_cnt + m_step;
        end else if (m_mode == M_PAUSE) begin
            if (acc && op == 2'd1) m_mode = M_RUN;
            else if (acc && op == 2'd3) m_mode = M_IDLE;
        end else if (m_mode == M_DONE) begin
            m_mode = M_IDLE;
        end
        @(posedge clk); #1;
        chk({tag, " cnt"},   32'(outCounter), 32'(m_cnt));
        chk({tag, " busy"},  32'(busy),  32'(m_mode == M_RUN || m_mode == M_PAUSE));
        chk({tag, " done"},  32'(done),  32'(m_mode == M_DONE));
        chk({tag, " wrap"},  32'(wrap),  32'(m_wrap));
        chk({tag, " ready"}, 32'(cmd_ready), 32'(m_mode != M_DONE));
    endtask

    task automatic nop(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 2'd0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        // Reset state
        cyc("reset", 1'b1, 1'b0, 2'd0, 0, 0, 0, 1'b0);
        chk("reset ready const", 32'(cmd_ready), 32'd1);

        // Non-wrapping run 90 -> 100 step 5
        cyc("tp1", 1'b0, 1'b1, 2'd1, 90, 100, 5, 1'b0);
        chk("tp1 first", 32'(outCounter), 32'd90);
        nop("tp1", 1);
        chk("tp1 second", 32'(outCounter), 32'd95);
        nop("tp1", 1);
        chk("tp1 final", 32'(outCounter), 32'd100);
        chk("tp1 done", 32'(done), 32'd1);
        nop("tp1", 2);
        chk("tp1 hold", 32'(outCounter), 32'd100);

        // Wrapping run 10/20/4
        cyc("tp2", 1'b0, 1'b1, 2'd1, 10, 20, 4, 1'b1);
        nop("tp2", 3);
        chk("tp2 wrap val", 32'(outCounter), 32'd10);
        chk("tp2 wrap pulse", 32'(wrap), 32'd1);
        nop("tp2", 6);
        cyc("tp2 abort", 1'b0, 1'b1, 2'd3, 0, 0, 0, 1'b0);

        // No 8-bit overflow near 255
        cyc("tp3", 1'b0, 1'b1, 2'd1, 250, 255, 10, 1'b0);
        nop("tp3", 1);
        chk("tp3 sat", 32'(outCounter), 32'd255);
        nop("tp3", 2);

        // Pause / resume / abort
        cyc("tp4", 1'b0, 1'b1, 2'd1, 0, 100, 1, 1'b0);
        nop("tp4", 40);
        cyc("tp4 pause", 1'b0, 1'b1, 2'd2, 0, 0, 0, 1'b0);
        nop("tp4 held", 5);
        chk("tp4 held40", 32'(outCounter), 32'd40);
        cyc("tp4 resume", 1'b0, 1'b1, 2'd1, 77, 5, 9, 1'b1);
        nop("tp4", 1);
        chk("tp4 41", 32'(outCounter), 32'd41);
        nop("tp4", 19);
        cyc("tp4 abort", 1'b0, 1'b1, 2'd3, 0, 0, 0, 1'b0);
        nop("tp4 idle", 2);
        chk("tp4 hold60", 32'(outCounter), 32'd60);

        // Step 0 treated as 1; start == limit finishes immediately
        cyc("tp5", 1'b0, 1'b1, 2'd1, 0, 3, 0, 1'b0);
        nop("tp5", 3);
        chk("tp5 end3", 32'(outCounter), 32'd3);
        nop("tp5", 1);
        cyc("tp5 eq", 1'b0, 1'b1, 2'd1, 7, 7, 2, 1'b0);
        chk("tp5 eq done", 32'(done), 32'd1);
        nop("tp5 eq", 2);

        // Reset overrides an accepted START, and a run in progress
        cyc("tp6 rst+start", 1'b1, 1'b1, 2'd1, 5, 50, 1, 1'b0);
        cyc("tp6", 1'b0, 1'b1, 2'd1, 0, 100, 1, 1'b0);
        nop("tp6", 50);
        chk("tp6 at50", 32'(outCounter), 32'd50);
        cyc("tp6 rst", 1'b1, 1'b0, 2'd0, 0, 0, 0, 1'b0);
        nop("tp6 after", 2);

        // Random commands
        for (int i = 0; i < 600; i++) begin
            int sel;
            bit [1:0] op;
            sel = $urandom_range(0, 19);
            op  = (sel < 12) ? 2'd0 : (sel < 15) ? 2'd1 : (sel < 18) ? 2'd2 : 2'd3;
            cyc("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), op,
                $urandom_range(0, 255),
                ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255),
                $urandom_range(0, 40), $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
